// File: rtl/mm2s_rd_arbiter.sv
// Round-robin arbiter merging N_REQ MM2S read requesters onto one AXI read master; R beats return in issue order.
// Optional per-requester beat counters are enabled by defining MM2S_RD_ARB_STATS_EN.
module mm2s_rd_arbiter #(
  parameter int N_REQ          = 3,
  parameter int AXI_WIDTH      = 128,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 6,
  parameter int MAX_OUT        = 4,
  parameter int RD_ID          = 0
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [N_REQ-1:0][AXI_ADDR_WIDTH-1:0]      s_araddr,
  input  logic [N_REQ-1:0][AXI_ID_WIDTH-1:0]        s_arid,
  input  logic [N_REQ-1:0][7:0]                     s_arlen,
  input  logic [N_REQ-1:0][2:0]                     s_arsize,
  input  logic [N_REQ-1:0][1:0]                     s_arburst,
  input  logic [N_REQ-1:0]                          s_arvalid,
  output logic [N_REQ-1:0]                          s_arready,
  output logic [N_REQ-1:0][AXI_WIDTH-1:0]           s_rdata,
  output logic [N_REQ-1:0][1:0]                     s_rresp,
  output logic [N_REQ-1:0]                          s_rlast,
  output logic [N_REQ-1:0][AXI_ID_WIDTH-1:0]        s_rid,
  output logic [N_REQ-1:0]                          s_rvalid,
  input  logic [N_REQ-1:0]                          s_rready,
  output logic [AXI_ADDR_WIDTH-1:0]                 m_araddr,
  output logic [AXI_ID_WIDTH-1:0]                   m_arid,
  output logic [7:0]                                m_arlen,
  output logic [2:0]                                m_arsize,
  output logic [1:0]                                m_arburst,
  output logic                                      m_arvalid,
  input  logic                                      m_arready,
  input  logic [AXI_WIDTH-1:0]                      m_rdata,
  input  logic [1:0]                                m_rresp,
  input  logic                                      m_rlast,
  input  logic [AXI_ID_WIDTH-1:0]                   m_rid,
  input  logic                                      m_rvalid,
  output logic                                      m_rready,
  output logic                                      dbg_ar_state,
`ifdef MM2S_RD_ARB_STATS_EN
  output logic [N_REQ-1:0][31:0]                    stat_beats,
`endif
  output logic                                      err_unexp_r
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW = PW + 1;

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} ar_state_t;

  ar_state_t                 state, state_nxt;
  logic [GW-1:0]             last_grant, winner, grant_q;
  logic                      grant, ar_hs, r_hs, pop, full, empty;
  logic [CW-1:0]             count;
  logic [PW-1:0]             wr_ptr, rd_ptr;
  logic [GW-1:0]             fifo_req [MAX_OUT];
  logic [AXI_ID_WIDTH-1:0]   fifo_id  [MAX_OUT];
  logic [AXI_ID_WIDTH-1:0]   id_q;
  logic [GW-1:0]             head;
  logic [AXI_ID_WIDTH-1:0]   head_id;
  logic                      rid_unused;

  // Nearest requesting index after last, scanning downwards so the closest one wins.
  function automatic logic [GW-1:0] rr_next(input logic [GW-1:0] last, input logic [N_REQ-1:0] req);
    logic [GW-1:0] pick;
    int            idx;
    pick = last;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = int'(last) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req[idx]) pick = GW'(idx);
    end
    return pick;
  endfunction

  assign winner       = rr_next(last_grant, s_arvalid);
  assign full         = (count == CW'(MAX_OUT));
  assign empty        = (count == '0);
  assign grant        = (state == IDLE) && !full && (|s_arvalid);
  assign ar_hs        = (state == ISSUE) && m_arready;
  assign dbg_ar_state = (state == ISSUE);
  assign rid_unused   = ^m_rid;

  always_comb begin
    state_nxt = state;
    s_arready = '0;
    m_arvalid = 1'b0;
    case (state)
      IDLE: begin
        if (grant) begin
          s_arready = N_REQ'(1) << winner;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        m_arvalid = 1'b1;
        if (m_arready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= GW'(N_REQ - 1);
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      err_unexp_r <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ar_hs) begin
        last_grant <= grant_q;
        wr_ptr     <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (ar_hs && !pop) count <= count + 1'b1;
      else if (!ar_hs && pop) count <= count - 1'b1;
      if (m_rvalid && empty) err_unexp_r <= 1'b1;
    end
  end

  // Payload registers need no reset: they are only observed behind m_arvalid or a non-empty FIFO.
  always_ff @(posedge clk) begin
    if (grant) begin
      grant_q   <= winner;
      m_araddr  <= s_araddr[winner];
      id_q      <= s_arid[winner];
      m_arlen   <= s_arlen[winner];
      m_arsize  <= s_arsize[winner];
      m_arburst <= s_arburst[winner];
    end
    if (ar_hs) begin
      fifo_req[wr_ptr] <= grant_q;
      fifo_id[wr_ptr]  <= id_q;
    end
  end

  assign m_arid   = AXI_ID_WIDTH'(RD_ID);
  assign head     = fifo_req[rd_ptr];
  assign head_id  = fifo_id[rd_ptr];
  assign m_rready = !empty && s_rready[head];
  assign s_rvalid = (!empty && m_rvalid) ? (N_REQ'(1) << head) : '0;
  assign r_hs     = m_rvalid && m_rready;
  assign pop      = r_hs && m_rlast;

  for (genvar g = 0; g < N_REQ; g++) begin : g_bcast
    assign s_rdata[g] = m_rdata;
    assign s_rresp[g] = m_rresp;
    assign s_rlast[g] = m_rlast;
    assign s_rid[g]   = head_id;
  end

`ifdef MM2S_RD_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) stat_beats <= '0;
    else if (r_hs) stat_beats[head] <= stat_beats[head] + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mm2s_rd_arbiter.sv
// Self-checking bench for mm2s_rd_arbiter: directed phases plus a randomized run against a transaction-level model.
// Define MM2S_RD_ARB_STATS_EN to also check the per-requester beat counters.
module tb_mm2s_rd_arbiter;

  localparam int N    = 3;
  localparam int W    = 128;
  localparam int AW   = 32;
  localparam int IW   = 6;
  localparam int MO   = 4;
  localparam int RDID = 5;
  localparam int EW   = 16 + IW;

  logic                  clk;
  logic                  rst;
  logic [N-1:0][AW-1:0]  s_araddr;
  logic [N-1:0][IW-1:0]  s_arid;
  logic [N-1:0][7:0]     s_arlen;
  logic [N-1:0][2:0]     s_arsize;
  logic [N-1:0][1:0]     s_arburst;
  logic [N-1:0]          s_arvalid;
  logic [N-1:0]          s_arready;
  logic [N-1:0][W-1:0]   s_rdata;
  logic [N-1:0][1:0]     s_rresp;
  logic [N-1:0]          s_rlast;
  logic [N-1:0][IW-1:0]  s_rid;
  logic [N-1:0]          s_rvalid;
  logic [N-1:0]          s_rready;
  logic [AW-1:0]         m_araddr;
  logic [IW-1:0]         m_arid;
  logic [7:0]            m_arlen;
  logic [2:0]            m_arsize;
  logic [1:0]            m_arburst;
  logic                  m_arvalid;
  logic                  m_arready;
  logic [W-1:0]          m_rdata;
  logic [1:0]            m_rresp;
  logic                  m_rlast;
  logic [IW-1:0]         m_rid;
  logic                  m_rvalid;
  logic                  m_rready;
  logic                  dbg_ar_state;
  logic                  err_unexp_r;
`ifdef MM2S_RD_ARB_STATS_EN
  logic [N-1:0][31:0]    stat_beats;
`endif

  mm2s_rd_arbiter #(
    .N_REQ(N), .AXI_WIDTH(W), .AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW), .MAX_OUT(MO), .RD_ID(RDID)
  ) dut (
    .clk(clk), .rst(rst),
    .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rid(s_rid),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_araddr(m_araddr), .m_arid(m_arid), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rid(m_rid),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .dbg_ar_state(dbg_ar_state),
`ifdef MM2S_RD_ARB_STATS_EN
    .stat_beats(stat_beats),
`endif
    .err_unexp_r(err_unexp_r)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  int checks = 0;
  int errors = 0;

  int arv_stall = 0, mar_stall = 0, r_stall = 0, rr_stall = 0;
  logic slave_en = 1'b0;
  logic unexp_mode = 1'b0;
  logic [7:0] req_len_q [N][$];
  logic [31:0] exp_sum [N];

  // Model state, owned by the monitor.
  logic [EW-1:0] exp_q[$];
  logic          pend_valid;
  int            pend_req;
  logic [AW-1:0] pend_addr;
  logic [IW-1:0] pend_id;
  logic [7:0]    pend_len;
  logic [2:0]    pend_size;
  logic [1:0]    pend_burst;
  int            last_m;
  logic          err_exp;
  logic [31:0]   mon_beats [N];
  int            mar_log_req[$];
  int            mar_log_cyc[$];
  int            r_log[$];
  int            pop_log_cyc[$];
  int            cyc = 0;
  logic [N-1:0]  ar_hs = '0;
  logic          r_hs = 1'b0;
  logic [7:0]    slv_q[$];
  int            slv_beat = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- monitor / reference model ----------------
  always @(negedge clk) begin : mon
    logic [N-1:0]  exp_rdy;
    logic [N-1:0]  hs;
    logic [EW-1:0] e;
    int            win, h;
    cyc++;
    ar_hs = '0;
    r_hs  = 1'b0;
    if (rst) begin
      exp_q.delete();
      pend_valid = 1'b0;
      last_m     = N - 1;
      err_exp    = 1'b0;
      for (int i = 0; i < N; i++) mon_beats[i] = '0;
    end else begin
      // AR: at most one grant while nothing is waiting downstream and fewer than MO bursts are outstanding.
      exp_rdy = '0;
      win = -1;
      for (int k = 1; k <= N; k++)
        if (win < 0 && s_arvalid[(last_m + k) % N]) win = (last_m + k) % N;
      if (!pend_valid && exp_q.size() < MO && win >= 0) exp_rdy[win] = 1'b1;
      chk("s_arready", s_arready, exp_rdy);
      chk("m_arvalid", m_arvalid, pend_valid);
      chk("dbg_ar_state", dbg_ar_state, pend_valid);
      if (pend_valid) begin
        chk("m_araddr", m_araddr, pend_addr);
        chk("m_arlen", m_arlen, pend_len);
        chk("m_arsize", m_arsize, pend_size);
        chk("m_arburst", m_arburst, pend_burst);
        chk("m_arid", m_arid, RDID);
      end
`ifdef MM2S_RD_ARB_STATS_EN
      for (int i = 0; i < N; i++) chk("stat_beats_live", stat_beats[i], mon_beats[i]);
`endif
      // R: routed to the oldest outstanding burst.
      chk("err_unexp_r", err_unexp_r, err_exp);
      if (exp_q.size() == 0) begin
        chk("m_rready_empty", m_rready, 1'b0);
        chk("s_rvalid_empty", s_rvalid, '0);
        if (m_rvalid) err_exp = 1'b1;
      end else begin
        e = exp_q[0];
        h = int'(e[IW+15:IW+8]);
        chk("s_rvalid", s_rvalid, m_rvalid ? (N'(1) << h) : N'(0));
        chk("m_rready", m_rready, s_rready[h]);
        chk("s_rid", s_rid[h], e[IW-1:0]);
        chk("s_rdata", s_rdata[h], m_rdata);
        chk("s_rresp", s_rresp[h], m_rresp);
        chk("s_rlast", s_rlast[h], m_rlast);
        if (m_rvalid && m_rready) begin
          r_hs = 1'b1;
          r_log.push_back(h);
          mon_beats[h] = mon_beats[h] + 32'd1;
          if (m_rlast) begin
            void'(exp_q.pop_front());
            pop_log_cyc.push_back(cyc);
          end
        end
      end
      if (pend_valid && m_arready) begin
        e = {8'(pend_req), pend_len, pend_id};
        exp_q.push_back(e);
        slv_q.push_back(pend_len);
        last_m = pend_req;
        mar_log_req.push_back(pend_req);
        mar_log_cyc.push_back(cyc);
        pend_valid = 1'b0;
      end
      hs = s_arvalid & s_arready;
      ar_hs = hs;
      for (int i = N - 1; i >= 0; i--) begin
        if (hs[i]) begin
          pend_valid = 1'b1;
          pend_req   = i;
          pend_addr  = s_araddr[i];
          pend_id    = s_arid[i];
          pend_len   = s_arlen[i];
          pend_size  = s_arsize[i];
          pend_burst = s_arburst[i];
        end
      end
    end
  end

  // ---------------- downstream slave responder ----------------
  always @(posedge clk) begin : slave
    #2;
    if (rst) begin
      slv_q.delete();
      slv_beat = 0;
      m_rvalid = 1'b0;
      m_rlast  = 1'b0;
    end else begin
      if (r_hs) begin
        if (m_rlast) begin
          void'(slv_q.pop_front());
          slv_beat = 0;
        end else slv_beat++;
      end
      if (unexp_mode) begin
        m_rvalid = 1'b1;
        m_rlast  = 1'b1;
        m_rdata  = {4{$urandom}};
      end else if (m_rvalid && !r_hs && slv_q.size() > 0) begin
        m_rvalid = 1'b1;
      end else if (slave_en && slv_q.size() > 0 && $urandom_range(99) >= r_stall) begin
        m_rvalid = 1'b1;
        m_rdata  = {$urandom, $urandom, $urandom, $urandom};
        m_rresp  = 2'($urandom);
        m_rid    = IW'($urandom);
        m_rlast  = (slv_beat == int'(slv_q[0]));
      end else begin
        m_rvalid = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (ar_hs[i]) s_arvalid[i] = 1'b0;
      if (!s_arvalid[i] && req_len_q[i].size() > 0 && $urandom_range(99) >= arv_stall) begin
        s_arlen[i]   = req_len_q[i].pop_front();
        s_araddr[i]  = $urandom;
        s_arid[i]    = IW'($urandom);
        s_arsize[i]  = 3'($urandom);
        s_arburst[i] = 2'($urandom);
        s_arvalid[i] = 1'b1;
      end
      s_rready[i] = ($urandom_range(99) >= rr_stall);
    end
    m_arready = ($urandom_range(99) >= mar_stall);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    s_arvalid = '0;
    for (int i = 0; i < N; i++) begin
      req_len_q[i].delete();
      exp_sum[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic queue_req(input int i, input int len);
    req_len_q[i].push_back(8'(len));
    exp_sum[i] = exp_sum[i] + 32'(len + 1);
  endtask

  function automatic logic is_idle();
    logic q_empty = 1'b1;
    for (int i = 0; i < N; i++) if (req_len_q[i].size() > 0) q_empty = 1'b0;
    return q_empty && (s_arvalid == '0) && !pend_valid && (exp_q.size() == 0);
  endfunction

  task automatic run_until_idle(input int budget, input string tag);
    int n = 0;
    while (!is_idle() && n < budget) begin
      step();
      n++;
    end
    chk(tag, is_idle(), 1'b1);
  endtask

  task automatic wait_mar(input int target, input int budget, input string tag);
    int n = 0;
    while (mar_log_req.size() < target && n < budget) begin
      step();
      n++;
    end
    chk(tag, mar_log_req.size() >= target, 1'b1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin : main
    int base, rbase, pbase;
    rst = 1'b1;
    s_araddr = '0; s_arid = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
    s_arvalid = '0; s_rready = '1; m_arready = 1'b1;
    m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rid = '0; m_rvalid = 1'b0;
    for (int i = 0; i < N; i++) exp_sum[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_s_arready", s_arready, '0);
    chk("rst_m_arvalid", m_arvalid, 1'b0);
    chk("rst_m_rready", m_rready, 1'b0);
    chk("rst_err", err_unexp_r, 1'b0);

    // All three requesting from reset: grants 0,1,2,0, one every two cycles.
    slave_en = 1'b1;
    for (int i = 0; i < N; i++) begin
      queue_req(i, 0);
      queue_req(i, 0);
    end
    wait_mar(4, 50, "a_wait_ar");
    chk("a_grant0", mar_log_req[0], 0);
    chk("a_grant1", mar_log_req[1], 1);
    chk("a_grant2", mar_log_req[2], 2);
    chk("a_grant3", mar_log_req[3], 0);
    for (int k = 1; k < 4; k++) chk("a_spacing", mar_log_cyc[k] - mar_log_cyc[k-1], 2);
    run_until_idle(200, "a_drain");

    // Requester 1 eight beats, then requester 0 four beats, returned in issue order.
    do_reset();
    slave_en = 1'b0;
    base  = mar_log_req.size();
    rbase = r_log.size();
    queue_req(1, 7);
    wait_mar(base + 1, 50, "b_ar1");
    queue_req(0, 3);
    wait_mar(base + 2, 50, "b_ar0");
    slave_en = 1'b1;
    run_until_idle(200, "b_drain");
    chk("b_beats", r_log.size() - rbase, 12);
    for (int k = 0; k < 12; k++) chk("b_route", r_log[rbase + k], (k < 8) ? 1 : 0);

    // Five requests with R stalled: only MO accepted until the first burst completes.
    slave_en = 1'b0;
    base  = mar_log_req.size();
    pbase = pop_log_cyc.size();
    queue_req(0, 1); queue_req(0, 1);
    queue_req(1, 1); queue_req(1, 1);
    queue_req(2, 1);
    wait_mar(base + 4, 100, "c_ar4");
    repeat (10) step();
    @(negedge clk);
    chk("c_ar_count", mar_log_req.size() - base, 4);
    chk("c_5th_blocked", s_arready, '0);
    chk("c_5th_waiting", |s_arvalid, 1'b1);
    slave_en = 1'b1;
    wait_mar(base + 5, 100, "c_ar5");
    chk("c_5th_after_pop", mar_log_cyc[base + 4] > pop_log_cyc[pbase], 1'b1);
    run_until_idle(200, "c_drain");

    // R beat with nothing outstanding: refused and flagged until reset.
    unexp_mode = 1'b1;
    step();
    @(negedge clk);
    chk("d_m_rready", m_rready, 1'b0);
    step();
    @(negedge clk);
    chk("d_err_set", err_unexp_r, 1'b1);
    unexp_mode = 1'b0;
    repeat (5) step();
    @(negedge clk);
    chk("d_err_sticky", err_unexp_r, 1'b1);
    do_reset();
    @(negedge clk);
    chk("d_err_cleared", err_unexp_r, 1'b0);

    // Reset in the middle of an eight-beat burst.
    slave_en = 1'b1;
    rbase = r_log.size();
    queue_req(2, 7);
    begin
      int n = 0;
      while (r_log.size() < rbase + 3 && n < 100) begin
        step();
        n++;
      end
      chk("e_mid_burst", r_log.size() >= rbase + 3, 1'b1);
    end
    do_reset();
    @(negedge clk);
    chk("e_m_arvalid", m_arvalid, 1'b0);
    chk("e_m_rready", m_rready, 1'b0);
    chk("e_model_empty", exp_q.size(), 0);
    base = mar_log_req.size();
    for (int i = 0; i < N; i++) queue_req(i, 0);
    wait_mar(base + 1, 50, "e_ar_first");
    chk("e_first_grant", mar_log_req[base], 0);
    run_until_idle(200, "e_drain");

    // Randomized bursts with stalls on every interface.
    do_reset();
    arv_stall = 30; mar_stall = 30; r_stall = 30; rr_stall = 30;
    for (int b = 0; b < 100; b++) queue_req($urandom_range(N - 1), $urandom_range(15));
    run_until_idle(20000, "f_drain");
    arv_stall = 0; mar_stall = 0; r_stall = 0; rr_stall = 0;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk("f_beats", mon_beats[i], exp_sum[i]);
`ifdef MM2S_RD_ARB_STATS_EN
      chk("f_stat_beats", stat_beats[i], exp_sum[i]);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mm2s_rd_arbiter.md
MM2S_RD_ARBITER -- requirements
Module: mm2s_rd_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 3, number of MM2S read requesters (weights, x, accumulator).
REQ-002 The block SHALL have parameter AXI_WIDTH, default 128, R data width.
REQ-003 The block SHALL have parameter AXI_ADDR_WIDTH, default 32, address width.
REQ-004 The block SHALL have parameter AXI_ID_WIDTH, default 6, ID width.
REQ-005 The block SHALL have parameter MAX_OUT, default 4, maximum outstanding bursts (power of 2, >=2).
REQ-006 The block SHALL have parameter RD_ID, default 0, constant ARID driven downstream.
REQ-007 The block SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-008 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-009 The block SHALL have requester ports s_araddr/s_arid/s_arlen/s_arsize/s_arburst/s_arvalid, inputs, [N_REQ-1:0] x AXI widths: per-requester AR channels.
REQ-010 The block SHALL have port s_arready, output, [N_REQ-1:0]: AR accept.
REQ-011 The block SHALL have ports s_rdata/s_rresp/s_rlast/s_rid/s_rvalid, outputs, [N_REQ-1:0] x AXI widths: routed R channels.
REQ-012 The block SHALL have port s_rready, input, [N_REQ-1:0].
REQ-013 The block SHALL have ports m_araddr/m_arid/m_arlen/m_arsize/m_arburst/m_arvalid, outputs, and m_arready, input: shared AR master.
REQ-014 The block SHALL have ports m_rdata/m_rresp/m_rlast/m_rid/m_rvalid, inputs, and m_rready, output: shared R master; m_rid ignored.
REQ-015 The block SHALL have port err_unexp_r, output, 1 bit: sticky flag for R beat with no outstanding burst.

Function
REQ-016 AR FSM SHALL have states IDLE and ISSUE.
REQ-017 In IDLE with tracking FIFO not full and any s_arvalid: winner chosen round-robin starting at last_grant+1 (mod N_REQ); s_arready[winner] pulsed for exactly that cycle; AR fields registered; next state ISSUE.
REQ-018 In ISSUE: m_arvalid=1 with registered fields stable, m_arid=RD_ID; on m_arvalid&&m_arready, push {winner, s_arid} to FIFO, last_grant<=winner, return to IDLE.
REQ-019 AR throughput SHALL be at most one burst per two cycles; s_arready SHALL never be asserted in ISSUE or when FIFO full.
REQ-020 FIFO full SHALL be evaluated on registered count; a pop in the same cycle does not enable a grant that cycle.
REQ-021 R routing SHALL be combinational on FIFO head h: s_rvalid[h]=m_rvalid, all other s_rvalid=0; m_rready=s_rready[h]; s_rid[h]=stored ID; s_rdata/s_rresp/s_rlast broadcast to all requesters.
REQ-022 FIFO pop SHALL occur on m_rvalid&&m_rready&&m_rlast; simultaneous push and pop leaves count unchanged.
REQ-023 With FIFO empty, m_rready SHALL be 0; m_rvalid=1 in that state sets err_unexp_r until reset.
REQ-024 Bursts SHALL return in issue order (single downstream ID); zero added latency on R path.

Reset
REQ-025 On rst: state IDLE, m_arvalid=0, s_arready=0, FIFO empty, last_grant=N_REQ-1 (requester 0 served first), err_unexp_r=0.
REQ-026 rst mid-burst SHALL discard all outstanding entries; downstream slave must also be reset.

Configuration
REQ-027 With macro MM2S_RD_ARB_STATS_EN defined: output stat_beats [N_REQ-1:0][31:0] counts R handshakes per requester, reset 0, wraps at 2^32; undefined: port absent, no counters.

Verification
REQ-028 All three s_arvalid high from reset, arlen=0, m_arready=1 -> grants in order 0,1,2,0 on m_ar; one grant per 2 cycles.
REQ-029 Req1 burst arlen=7 then req0 arlen=3, slave returns 8+4 beats -> 8 beats on s_rvalid[1] only, then 4 on s_rvalid[0]; s_rid echoes each requester ID.
REQ-030 m_arready=1, R stalled, 5 requests queued -> 4 AR handshakes, 5th s_arready stays 0 until first rlast pops.
REQ-031 m_rvalid=1 with no outstanding burst -> m_rready=0, err_unexp_r=1 next cycle, stays 1 until rst.
REQ-032 rst asserted mid 8-beat burst -> next cycle m_arvalid=0, FIFO empty, requester 0 granted first after release.
REQ-033 With MM2S_RD_ARB_STATS_EN, random READY/VALID stalls, 100 bursts -> stat_beats per requester equals sum of (arlen+1) issued.
